uart_rx_capture: RTL and testbench

UART_RX_CAPTURE -- requirements
Module: uart_rx_capture

---
 rtl/uart_rx_capture.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: oversampling-free UART receiver (mid-bit sampling) with a
// first-word-fall-through receive FIFO and one-cycle error/overflow pulses.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit and the
// PARITY state; without it the frame is 8N1 and o_parity_err is tied low).
module uart_rx_capture #(
  parameter int unsigned CLK_FREQ_HZ = 32'd12_500_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_overflow,
  output logic       o_busy
);

  localparam int unsigned DIV   = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int          CNT_W = $clog2(DIV + 1);
  localparam int          AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2;
  logic             w_rx_s;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_tick;
  logic             w_push_set, w_ferr_set;
  logic             r_push, r_frame_err, r_overflow;
`ifdef UART_RX_PARITY_EN
  logic             r_perr_flag, w_perr_flag_nxt;
  logic             w_perr_set, r_parity_err;
`endif

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr, r_rd;
  logic             w_empty, w_full, w_pop, w_push_ok, w_drop;

  assign w_rx_s = r_sync2;
  // A count of one marks the last cycle of the current wait period.
  assign w_tick = (r_cnt == C_ONE);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state, counter, shift and event logic for the receive FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push_set  = 1'b0;
    w_ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_flag_nxt = r_perr_flag;
    w_perr_set      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = C_HALF;
          w_bit_nxt   = 3'd0;
`ifdef UART_RX_PARITY_EN
          w_perr_flag_nxt = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          // Line back high at mid start bit: treat as a glitch.
          if (!w_rx_s) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = C_DIV;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_cnt_nxt   = C_DIV;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
            w_bit_nxt = 3'd0;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_perr_flag_nxt = (w_rx_s != (^r_shift));
          w_state_nxt     = S_STOP;
          w_cnt_nxt       = C_DIV;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
            w_perr_set = r_perr_flag;
            w_push_set = !r_perr_flag;
`else
            w_push_set = 1'b1;
`endif
            w_state_nxt = S_IDLE;
          end else begin
            // Bad stop bit: drop the byte and wait out any line break.
            w_ferr_set  = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_set  = r_perr_flag;
`endif
            w_state_nxt = S_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_WAIT_IDLE: begin
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control registers: bit timer, bit index, push request and status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_flag  <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_push      <= w_push_set;
      r_frame_err <= w_ferr_set;
      r_overflow  <= w_drop;
`ifdef UART_RX_PARITY_EN
      r_perr_flag  <= w_perr_flag_nxt;
      r_parity_err <= w_perr_set;
`endif
    end
  end

  // Receive shift register; pure data, so no reset.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // FIFO status: extra pointer MSB separates full from empty.
  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop     = !w_empty && i_ready;
  assign w_push_ok = r_push && (!w_full || w_pop);
  assign w_drop    = r_push && w_full && !w_pop;

  // FIFO pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
    end
  end

  // FIFO storage; the byte is still held in the shift register at push time.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr[AW-1:0]] <= r_shift;
  end

  assign o_valid     = !w_empty;
  assign o_data      = w_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
  assign o_frame_err = r_frame_err;
  assign o_overflow  = r_overflow;
  assign o_busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture at DIV = 10, FIFO_DEPTH = 4.
module tb_uart_rx_capture;

  localparam int DIV = 10;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_EXP = 108;
`else
  localparam int LAT_EXP = 98;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_parity_err, o_overflow, o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc      = 0;
  int rise_cyc = -1;
  int n_ferr   = 0;
  int n_perr   = 0;
  int n_ovf    = 0;
  int n_busy   = 0;
  logic prev_v = 1'b0;
  logic [7:0] popped [$];

  uart_rx_capture #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err),
    .o_overflow  (o_overflow),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_frame_err)  n_ferr++;
    if (o_parity_err) n_perr++;
    if (o_overflow)   n_ovf++;
    if (o_busy)       n_busy++;
    if (o_valid && !prev_v) rise_cyc = cyc;
    prev_v = o_valid;
    if (o_valid && i_ready) popped.push_back(o_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b);
    send_data(d);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, fe0, ov0, pe0, b0, fall_cyc, lat;

    // Reset state
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 8'h00);
    check("rst_ferr", o_frame_err, 0);
    check("rst_perr", o_parity_err, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_busy", o_busy, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(5);

    // Single 0x55 frame: latency, data, busy
    base = popped.size(); b0 = n_busy;
    fall_cyc = cyc;
    send_frame(8'h55, ^8'h55, 1'b1);
    idle(20);
    lat = rise_cyc - fall_cyc;
    check("lat_in_window", (lat >= LAT_EXP - 2) && (lat <= LAT_EXP + 2), 1);
    check("b55_count", popped.size() - base, 1);
    if (popped.size() > base) check("b55_data", popped[base], 8'h55);
    check("b55_busy", (n_busy - b0) > 80, 1);
    check("b55_idle", o_busy, 0);

    // Short glitch is rejected silently
    base = popped.size(); fe0 = n_ferr; pe0 = n_perr;
    i_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(30);
    check("glitch_nopush", popped.size() - base, 0);
    check("glitch_ferr", n_ferr - fe0, 0);
    check("glitch_perr", n_perr - pe0, 0);
    check("glitch_busy", o_busy, 0);

    // Bad stop bit with line break, then a good frame
    base = popped.size(); fe0 = n_ferr;
    send_frame(8'hA3, ^8'hA3, 1'b0);
    i_rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("brk_busy", o_busy, 1);
    idle(20);
    check("brk_ferr_once", n_ferr - fe0, 1);
    check("brk_nopush", popped.size() - base, 0);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    idle(20);
    check("b3c_count", popped.size() - base, 1);
    if (popped.size() > base) check("b3c_data", popped[base], 8'h3C);

    // Overflow: five frames into a four-entry FIFO with no consumer
    i_ready = 1'b0;
    base = popped.size(); ov0 = n_ovf;
    for (int k = 1; k <= 4; k++) send_frame(8'(k), ^8'(k), 1'b1);
    idle(5);
    check("ovf_none_yet", n_ovf - ov0, 0);
    send_frame(8'h05, ^8'h05, 1'b1);
    idle(20);
    check("ovf_once", n_ovf - ov0, 1);
    check("ovf_head_valid", o_valid, 1);
    check("ovf_head_hold", o_data, 8'h01);
    i_ready = 1'b1;
    idle(10);
    check("ovf_pop_count", popped.size() - base, 4);
    for (int k = 0; k < 4; k++)
      if (popped.size() > base + k) check("ovf_pop_order", popped[base + k], 8'(k + 1));
    check("ovf_drained", o_valid, 0);

    // Reset in the middle of a frame, with a byte parked in the FIFO
    i_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1);
    idle(5);
    check("pre_rst_valid", o_valid, 1);
    base = popped.size();
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    i_rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", o_busy, 1);
    rstn = 1'b0;
    i_rx = 1'b1;
    #1;
    check("mrst_valid", o_valid, 0);
    check("mrst_data", o_data, 8'h00);
    check("mrst_busy", o_busy, 0);
    check("mrst_ferr", o_frame_err, 0);
    check("mrst_ovf", o_overflow, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    i_ready = 1'b1;
    idle(20);
    check("mrst_nopush", popped.size() - base, 0);
    send_frame(8'h9E, ^8'h9E, 1'b1);
    idle(20);
    check("b9e_count", popped.size() - base, 1);
    if (popped.size() > base) check("b9e_data", popped[base], 8'h9E);

`ifdef UART_RX_PARITY_EN
    // Parity mismatch discards; correct parity delivers
    base = popped.size(); pe0 = n_perr; fe0 = n_ferr;
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    check("par_err_once", n_perr - pe0, 1);
    check("par_err_nopush", popped.size() - base, 0);
    check("par_no_ferr", n_ferr - fe0, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("par_ok_count", popped.size() - base, 1);
    if (popped.size() > base) check("par_ok_data", popped[base], 8'h07);
    check("par_ok_noerr", n_perr - pe0, 1);
`else
    check("perr_tied", n_perr, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
